// File: rtl/stein_gcd_engine.sv
// Binary (Stein) GCD engine: start/ready handshake, one reduction step per clk,
// one-cycle done pulse with the result and the REDUCE cycle count.
module stein_gcd_engine #(
  parameter  int WIDTH = 8,
  localparam int K_W   = $clog2(WIDTH + 1),
  localparam int CNT_W = $clog2(2 * WIDTH + 2)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  // The larger operand is always the minuend, so these never wrap when used.
  logic [WIDTH-1:0] diff_xy;
  logic [WIDTH-1:0] diff_yx;

  assign diff_xy = x_q - y_q;
  assign diff_yx = y_q - x_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    cyc_d   = cyc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = xin;
          y_d     = yin;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_REDUCE;
        end
      end

      S_REDUCE: begin
        cnt_d = cnt_q + 1'b1;
        if (x_q == '0) begin
          gcd_d   = y_q << k_q;
          cyc_d   = cnt_q + 1'b1;
          state_d = S_DONE;
        end else if (y_q == '0 || x_q == y_q) begin
          gcd_d   = x_q << k_q;
          cyc_d   = cnt_q + 1'b1;
          state_d = S_DONE;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + 1'b1;
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          x_d = diff_xy >> 1;
        end else begin
          y_d = diff_yx >> 1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_REDUCE);
  assign done   = (state_q == S_DONE);
  assign gcd    = gcd_q;
  assign cycles = cyc_q;

endmodule

// File: tb/tb_stein_gcd_engine.sv
// Bench for stein_gcd_engine: 8-bit and 16-bit instances, vector table,
// handshake/reset sequences and randomised pairs against a reference model.
module tb_stein_gcd_engine;

  logic        clk = 1'b0;
  logic        clr = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  xin8 = '0, yin8 = '0;
  logic        ready8, busy8, done8;
  logic [7:0]  gcd8;
  logic [4:0]  cyc8;

  logic        start16 = 1'b0;
  logic [15:0] xin16 = '0, yin16 = '0;
  logic        ready16, busy16, done16;
  logic [15:0] gcd16;
  logic [5:0]  cyc16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stein_gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .xin(xin8), .yin(yin8),
    .ready(ready8), .busy(busy8), .done(done8), .gcd(gcd8), .cycles(cyc8)
  );

  stein_gcd_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .start(start16), .xin(xin16), .yin(yin16),
    .ready(ready16), .busy(busy16), .done(done16), .gcd(gcd16), .cycles(cyc16)
  );

  typedef struct {
    int sel;   // 0: 8-bit instance, 1: 16-bit instance
    int x;
    int y;
    int g;
    int c;     // -1: only the step bound is checked
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Euclid, independent of the binary algorithm under test
  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Count of steps taken by the reduction rules, terminal step included
  function automatic int steps_ref(input int a, input int b);
    int n = 0;
    while (1) begin
      n++;
      if (a == 0 || b == 0 || a == b) return n;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = (a - b) / 2;
      else b = (b - a) / 2;
    end
    return n;
  endfunction

  function automatic logic f_rdy(input int sel);  return sel ? ready16 : ready8; endfunction
  function automatic logic f_bsy(input int sel);  return sel ? busy16 : busy8;   endfunction
  function automatic logic f_dn(input int sel);   return sel ? done16 : done8;   endfunction
  function automatic int   f_gcd(input int sel);  return sel ? int'(gcd16) : int'(gcd8); endfunction
  function automatic int   f_cyc(input int sel);  return sel ? int'(cyc16) : int'(cyc8); endfunction

  task automatic drive(input int sel, input logic s, input int x, input int y);
    if (sel != 0) begin
      start16 = s; xin16 = x[15:0]; yin16 = y[15:0];
    end else begin
      start8 = s;  xin8 = x[7:0];   yin8 = y[7:0];
    end
  endtask

  // Runs one operation and checks handshake timing along the way.
  task automatic run_op(input int sel, input int x, input int y,
                        output int g, output int c);
    int n = 0;
    int hs_bad = 0;
    logic seen = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, x, y);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, x, y);
    while (n < 100) begin
      @(negedge clk);
      if (f_dn(sel)) begin
        seen = 1'b1;
        break;
      end
      if (f_rdy(sel) || !f_bsy(sel)) hs_bad++;
      n++;
    end
    chk("done_seen", seen, 1);
    chk("busy_during_reduce", hs_bad, 0);
    chk("ready_low_in_done", f_rdy(sel), 0);
    g = f_gcd(sel);
    c = f_cyc(sel);
    @(negedge clk);
    chk("done_one_cycle", f_dn(sel), 0);
    chk("ready_after_done", f_rdy(sel), 1);
  endtask

  initial begin
    vec_t tbl[$];
    int g, c, dcount, w, x, y;
    logic seen;

    tbl.push_back('{0, 12, 18, 6, 4});
    tbl.push_back('{0, 48, 18, 6, 6});
    tbl.push_back('{0, 0, 5, 5, 1});
    tbl.push_back('{0, 9, 0, 9, 1});
    tbl.push_back('{0, 0, 0, 0, 1});
    tbl.push_back('{0, 7, 7, 7, 1});
    tbl.push_back('{0, 255, 1, 1, 8});
    tbl.push_back('{0, 128, 64, 64, 8});
    tbl.push_back('{0, 128, 128, 128, 1});
    tbl.push_back('{1, 65535, 4369, 4369, -1});
    tbl.push_back('{1, 40000, 30000, 10000, -1});
    tbl.push_back('{1, 32768, 65535, 1, -1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_gcd", gcd8, 0);
    chk("rst_cycles", cyc8, 0);
    chk("rst_ready16", ready16, 1);
    clr = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].sel, tbl[i].x, tbl[i].y, g, c);
      chk($sformatf("vec%0d_gcd", i), g, tbl[i].g);
      if (tbl[i].c >= 0) chk($sformatf("vec%0d_cycles", i), c, tbl[i].c);
      else chk($sformatf("vec%0d_cycles_bound", i), (c >= 1 && c <= 33), 1);
    end

    // start during REDUCE and DONE is ignored; operand changes after accept are ignored
    @(negedge clk);
    start8 = 1'b1; xin8 = 8'd48; yin8 = 8'd18;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    xin8 = 8'd1; yin8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    chk("hs_done_seen", seen, 1);
    chk("hs_gcd", gcd8, 6);
    chk("hs_cycles", cyc8, 6);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("hs_ready_after_done", ready8, 1);
    chk("hs_busy_after_done", busy8, 0);
    @(negedge clk);
    chk("hs_start_in_done_not_queued", busy8, 0);

    // Reset mid-REDUCE drops the operation
    @(negedge clk);
    start8 = 1'b1; xin8 = 8'd48; yin8 = 8'd18;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy8, 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", ready8, 1);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_gcd", gcd8, 0);
    chk("mid_rst_cycles", cyc8, 0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    // Randomised pairs, including occasional zero operands
    for (int r = 0; r < 1000; r++) begin
      int sel = (r < 200) ? 0 : 1;
      w = sel ? 16 : 8;
      x = int'($urandom_range((1 << w) - 1, 0));
      y = int'($urandom_range((1 << w) - 1, 0));
      if ($urandom_range(15, 0) == 0) x = 0;
      if ($urandom_range(15, 0) == 0) y = 0;
      if ($urandom_range(15, 0) == 0) y = x;
      run_op(sel, x, y, g, c);
      chk($sformatf("rnd_gcd(%0d,%0d)", x, y), g, gcd_ref(x, y));
      chk($sformatf("rnd_cycles(%0d,%0d)", x, y), c, steps_ref(x, y));
      chk("rnd_cycles_bound", (c <= 2 * w + 1), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
